stack_sequencer: RTL and testbench

Two-byte push/pop engine for the CPU stack. It owns SP and turns CPU stack commands into byte-wide memory transactions on the 8-bit data path. Commands are PUSH, POP, LOAD SP and ADD SP,e8. It is the memory-side counterpart of the stack pointer's address generation: it drives the stack address and data, sequences both bytes, and returns popped words to the register file.

---
 rtl/stack_sequencer.sv | 176 +++++++++++++++++
 tb/tb_stack_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// stack_sequencer: owns the CPU stack pointer and moves 16-bit stack words
// over an 8-bit memory port. PUSH writes the high byte first at SP-1, then
// the low byte at SP-2. POP reads the low byte at SP, then the high byte at
// SP+1. LOAD and ADJUST change SP without any memory traffic.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a command; resp pulse (if any) is shown here
// PUSH_HI | writing word[15:8] to SP-1, waiting for ack
// PUSH_LO | writing word[7:0] to SP-1 (SP already dropped once)
// POP_LO  | reading low byte from SP, waiting for ack
// POP_HI  | reading high byte from SP (SP already advanced once)
module stack_sequencer #(
    parameter logic [15:0] SP_RESET = 16'hFFFE
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [15:0] cmd_data_i,
    output logic        resp_valid_o,
    output logic [15:0] resp_data_o,
    output logic [1:0]  flags_o,
    output logic [15:0] sp_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [15:0] mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [7:0]  mem_rdata_i,
    input  logic        mem_ack_i
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PUSH_HI = 3'd1,
        PUSH_LO = 3'd2,
        POP_LO  = 3'd3,
        POP_HI  = 3'd4
    } stateType;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;

    stateType    state;
    logic [15:0] sp;
    logic [7:0]  loByte;
    logic        respValid;
    logic [15:0] respData;
    logic [1:0]  flags;
    logic        memReq;
    logic        memWe;
    logic [15:0] memAddr;
    logic [7:0]  memWdata;

    logic [15:0] spDec;
    logic [15:0] spDec2;
    logic [15:0] spInc;
    logic [7:0]  adjOffset;
    logic [8:0]  lowSum;
    logic [7:0]  adjHi;
    logic [15:0] adjSp;
    logic        adjHalf;

    // SP neighbours and the ADJUST sum; the half carry is recovered from
    // bit 4 of the low-byte sum so the adder is shared with the C flag.
    assign spDec     = sp - 16'd1;
    assign spDec2    = sp - 16'd2;
    assign spInc     = sp + 16'd1;
    assign adjOffset = cmd_data_i[7:0];
    assign lowSum    = {1'b0, sp[7:0]} + {1'b0, adjOffset};
    assign adjHi     = sp[15:8] + {8{adjOffset[7]}} + {7'd0, lowSum[8]};
    assign adjSp     = {adjHi, lowSum[7:0]};
    assign adjHalf   = lowSum[4] ^ sp[4] ^ adjOffset[4];

    // Command sequencing, SP bookkeeping and registered memory/response outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            sp        <= SP_RESET;
            loByte    <= 8'h00;
            respValid <= 1'b0;
            respData  <= 16'h0000;
            flags     <= 2'b00;
            memReq    <= 1'b0;
            memWe     <= 1'b0;
            memAddr   <= 16'h0000;
            memWdata  <= 8'h00;
        end else begin
            respValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        case (cmd_op_i)
                            OP_PUSH: begin
                                state    <= PUSH_HI;
                                memReq   <= 1'b1;
                                memWe    <= 1'b1;
                                memAddr  <= spDec;
                                memWdata <= cmd_data_i[15:8];
                                loByte   <= cmd_data_i[7:0];
                            end
                            OP_POP: begin
                                state   <= POP_LO;
                                memReq  <= 1'b1;
                                memWe   <= 1'b0;
                                memAddr <= sp;
                            end
                            OP_LOAD: begin
                                sp        <= cmd_data_i;
                                respData  <= cmd_data_i;
                                respValid <= 1'b1;
                            end
                            default: begin
                                sp        <= adjSp;
                                respData  <= adjSp;
                                respValid <= 1'b1;
                                flags     <= {adjHalf, lowSum[8]};
                            end
                        endcase
                    end
                end
                PUSH_HI: begin
                    if (mem_ack_i) begin
                        sp       <= spDec;
                        memAddr  <= spDec2;
                        memWdata <= loByte;
                        state    <= PUSH_LO;
                    end
                end
                PUSH_LO: begin
                    if (mem_ack_i) begin
                        sp        <= spDec;
                        memReq    <= 1'b0;
                        respData  <= spDec;
                        respValid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                POP_LO: begin
                    if (mem_ack_i) begin
                        loByte  <= mem_rdata_i;
                        sp      <= spInc;
                        memAddr <= spInc;
                        state   <= POP_HI;
                    end
                end
                POP_HI: begin
                    if (mem_ack_i) begin
                        sp        <= spInc;
                        memReq    <= 1'b0;
                        respData  <= {mem_rdata_i, loByte};
                        respValid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    memReq <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o  = (state == IDLE);
    assign resp_valid_o = respValid;
    assign resp_data_o  = respData;
    assign flags_o      = flags;
    assign sp_o         = sp;
    assign mem_req_o    = memReq;
    assign mem_we_o     = memWe;
    assign mem_addr_o   = memAddr;
    assign mem_wdata_o  = memWdata;

endmodule

// File: tb/tb_stack_sequencer.sv
// Testbench for stack_sequencer: byte-wide memory model with configurable
// wait states, a write log, and a queue of expected responses per command.
module tb_stack_sequencer;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_ADJ  = 2'b11;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i = 2'b00;
    logic [15:0] cmd_data_i = 16'h0000;
    logic        resp_valid_o;
    logic [15:0] resp_data_o;
    logic [1:0]  flags_o;
    logic [15:0] sp_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [15:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata_i = 8'h00;
    logic        mem_ack_i = 1'b0;

    logic [7:0]  mem [0:65535];
    bit          autoMem = 1'b1;
    logic        manualAck = 1'b0;
    int          waitCfg = 0;
    int          waitCnt = 0;
    logic [15:0] wrAddrQ[$];
    logic [7:0]  wrDataQ[$];
    logic [15:0] expQ[$];
    int          errors = 0;
    int          checks = 0;

    stack_sequencer dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_data_i(cmd_data_i),
        .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
        .flags_o(flags_o), .sp_o(sp_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Memory responder: ack after waitCfg wait cycles, or a test-driven ack.
    always @(negedge clk_i) begin
        #1;
        if (!autoMem) begin
            mem_ack_i = manualAck;
        end else if (mem_req_o && waitCnt >= waitCfg) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = mem[mem_addr_o];
            waitCnt     = 0;
        end else begin
            mem_ack_i = 1'b0;
            if (mem_req_o) waitCnt++;
        end
    end

    // Commit and log writes on the edge where the DUT sees the ack.
    always @(posedge clk_i) begin
        if (mem_req_o && mem_ack_i && mem_we_o) begin
            mem[mem_addr_o] = mem_wdata_o;
            wrAddrQ.push_back(mem_addr_o);
            wrDataQ.push_back(mem_wdata_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [1:0] op, input logic [15:0] d);
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_data_i  = d;
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b0;
    endtask

    // n = cycle after accept in which resp_valid is seen (1 = T+1), -1 on timeout
    task automatic waitResp(input int budget, output int n, output logic [15:0] d);
        n = -1;
        d = 16'hxxxx;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk_i);
            if (resp_valid_o) begin
                n = i;
                d = resp_data_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready_o); end
        checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid_o); end
        checks++; if (resp_data_o !== 16'h0000) begin errors++; $display("FAIL reset_resp_data: got %h want 0000", resp_data_o); end
        checks++; if (flags_o !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", flags_o); end
        checks++; if (sp_o !== 16'hFFFE) begin errors++; $display("FAIL reset_sp: got %h want fffe", sp_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req_o); end
        checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", mem_we_o); end
        checks++; if (mem_addr_o !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", mem_addr_o); end
        checks++; if (mem_wdata_o !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h want 00", mem_wdata_o); end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_push();
        int n;
        logic [15:0] d, e;
        wrAddrQ.delete();
        wrDataQ.delete();
        expQ.push_back(16'hFFFC);
        issue(OP_PUSH, 16'hBEEF);
        waitResp(20, n, d);
        e = expQ.pop_front();
        checks++; if (n !== 3) begin errors++; $display("FAIL push_latency: got %0d want 3", n); end
        checks++; if (d !== e) begin errors++; $display("FAIL push_resp: got %h want %h", d, e); end
        checks++; if (sp_o !== 16'hFFFC) begin errors++; $display("FAIL push_sp: got %h want fffc", sp_o); end
        checks++; if (wrAddrQ.size() !== 2) begin errors++; $display("FAIL push_wr_count: got %0d want 2", wrAddrQ.size()); end
        if (wrAddrQ.size() == 2) begin
            checks++; if (wrAddrQ[0] !== 16'hFFFD || wrDataQ[0] !== 8'hBE) begin errors++; $display("FAIL push_wr0: got %h@%h want be@fffd", wrDataQ[0], wrAddrQ[0]); end
            checks++; if (wrAddrQ[1] !== 16'hFFFC || wrDataQ[1] !== 8'hEF) begin errors++; $display("FAIL push_wr1: got %h@%h want ef@fffc", wrDataQ[1], wrAddrQ[1]); end
        end
    endtask

    task automatic test_pop();
        int n;
        logic [15:0] d, e;
        expQ.push_back(16'hBEEF);
        issue(OP_POP, 16'h0000);
        waitResp(20, n, d);
        e = expQ.pop_front();
        checks++; if (n !== 3) begin errors++; $display("FAIL pop_latency: got %0d want 3", n); end
        checks++; if (d !== e) begin errors++; $display("FAIL pop_resp: got %h want %h", d, e); end
        checks++; if (sp_o !== 16'hFFFE) begin errors++; $display("FAIL pop_sp: got %h want fffe", sp_o); end
    endtask

    task automatic test_pop_wait();
        int n;
        logic [15:0] d, e, a;
        mem[16'hFFFE] = 8'h5A;
        mem[16'hFFFF] = 8'hC3;
        waitCfg = 3;
        expQ.push_back(16'hC35A);
        issue(OP_POP, 16'h0000);
        n = -1;
        d = 16'hxxxx;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk_i);
            if (i <= 8) begin
                a = (i <= 4) ? 16'hFFFE : 16'hFFFF;
                checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== a) begin
                    errors++; $display("FAIL popw_hold c%0d: got req=%b we=%b addr=%h want 1 0 %h", i, mem_req_o, mem_we_o, mem_addr_o, a);
                end
            end
            if (i == 2) begin
                cmd_valid_i = 1'b1;
                cmd_op_i    = OP_LOAD;
                cmd_data_i  = 16'h1234;
            end
            if (i == 5) begin
                checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL popw_busy_ready: got %b want 0", cmd_ready_o); end
            end
            if (i == 6) cmd_valid_i = 1'b0;
            if (resp_valid_o) begin
                n = i;
                d = resp_data_o;
                break;
            end
        end
        waitCfg = 0;
        e = expQ.pop_front();
        checks++; if (n !== 9) begin errors++; $display("FAIL popw_latency: got %0d want 9", n); end
        checks++; if (d !== e) begin errors++; $display("FAIL popw_resp: got %h want %h", d, e); end
        checks++; if (sp_o !== 16'h0000) begin errors++; $display("FAIL popw_sp: got %h want 0000", sp_o); end
    endtask

    task automatic test_adjust();
        logic [15:0] ldVal [3];
        logic [15:0] offVal [3];
        logic [15:0] spExp [3];
        logic [1:0]  flExp [3];
        int n;
        logic [15:0] d, e;
        ldVal[0] = 16'h000F; offVal[0] = 16'h0001; spExp[0] = 16'h0010; flExp[0] = 2'b10;
        ldVal[1] = 16'h00FF; offVal[1] = 16'h00FF; spExp[1] = 16'h00FE; flExp[1] = 2'b11;
        ldVal[2] = 16'h1000; offVal[2] = 16'h0080; spExp[2] = 16'h0F80; flExp[2] = 2'b00;
        for (int i = 0; i < 3; i++) begin
            expQ.push_back(ldVal[i]);
            issue(OP_LOAD, ldVal[i]);
            waitResp(5, n, d);
            e = expQ.pop_front();
            checks++; if (n !== 1 || d !== e || sp_o !== e) begin
                errors++; $display("FAIL load%0d: got n=%0d resp=%h sp=%h want n=1 %h", i, n, d, sp_o, e);
            end
            expQ.push_back(spExp[i]);
            issue(OP_ADJ, offVal[i]);
            waitResp(5, n, d);
            e = expQ.pop_front();
            checks++; if (n !== 1 || d !== e) begin errors++; $display("FAIL adj%0d_resp: got n=%0d resp=%h want n=1 %h", i, n, d, e); end
            checks++; if (sp_o !== e) begin errors++; $display("FAIL adj%0d_sp: got %h want %h", i, sp_o, e); end
            checks++; if (flags_o !== flExp[i]) begin errors++; $display("FAIL adj%0d_flags: got %b want %b", i, flags_o, flExp[i]); end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_op_i    = OP_LOAD;
        cmd_data_i  = 16'h1000;
        @(posedge clk_i);
        #1;
        cmd_op_i   = OP_ADJ;
        cmd_data_i = 16'h0002;
        @(negedge clk_i);
        checks++; if (resp_valid_o !== 1'b1 || resp_data_o !== 16'h1000 || cmd_ready_o !== 1'b1) begin
            errors++; $display("FAIL b2b_first: got v=%b d=%h rdy=%b want 1 1000 1", resp_valid_o, resp_data_o, cmd_ready_o);
        end
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (resp_valid_o !== 1'b1 || resp_data_o !== 16'h1002 || sp_o !== 16'h1002) begin
            errors++; $display("FAIL b2b_second: got v=%b d=%h sp=%h want 1 1002 1002", resp_valid_o, resp_data_o, sp_o);
        end
        checks++; if (flags_o !== 2'b00) begin errors++; $display("FAIL b2b_flags: got %b want 00", flags_o); end
        @(negedge clk_i);
        checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_pulse_width: got %b want 0", resp_valid_o); end
    endtask

    task automatic test_wrap();
        int n;
        logic [15:0] d, e;
        expQ.push_back(16'h0001);
        issue(OP_LOAD, 16'h0001);
        waitResp(5, n, d);
        e = expQ.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL wrap_load: got %h want %h", d, e); end
        wrAddrQ.delete();
        wrDataQ.delete();
        expQ.push_back(16'hFFFF);
        issue(OP_PUSH, 16'h1234);
        waitResp(20, n, d);
        e = expQ.pop_front();
        checks++; if (n !== 3 || d !== e || sp_o !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_push: got n=%0d resp=%h sp=%h want 3 %h ffff", n, d, sp_o, e);
        end
        checks++; if (wrAddrQ.size() !== 2) begin errors++; $display("FAIL wrap_wr_count: got %0d want 2", wrAddrQ.size()); end
        if (wrAddrQ.size() == 2) begin
            checks++; if (wrAddrQ[0] !== 16'h0000 || wrDataQ[0] !== 8'h12) begin errors++; $display("FAIL wrap_wr0: got %h@%h want 12@0000", wrDataQ[0], wrAddrQ[0]); end
            checks++; if (wrAddrQ[1] !== 16'hFFFF || wrDataQ[1] !== 8'h34) begin errors++; $display("FAIL wrap_wr1: got %h@%h want 34@ffff", wrDataQ[1], wrAddrQ[1]); end
        end
        expQ.push_back(16'h1234);
        issue(OP_POP, 16'h0000);
        waitResp(20, n, d);
        e = expQ.pop_front();
        checks++; if (n !== 3 || d !== e) begin errors++; $display("FAIL wrap_pop: got n=%0d resp=%h want 3 %h", n, d, e); end
        checks++; if (sp_o !== 16'h0001) begin errors++; $display("FAIL wrap_pop_sp: got %h want 0001", sp_o); end
    endtask

    task automatic test_reset_mid();
        int sawResp;
        autoMem   = 1'b0;
        manualAck = 1'b0;
        issue(OP_PUSH, 16'hABCD);
        @(negedge clk_i);
        manualAck = 1'b1;
        @(negedge clk_i);
        manualAck = 1'b0;
        checks++; if (mem_req_o !== 1'b1 || sp_o !== 16'h0000 || mem_addr_o !== 16'hFFFF) begin
            errors++; $display("FAIL rstmid_lo_phase: got req=%b sp=%h addr=%h want 1 0000 ffff", mem_req_o, sp_o, mem_addr_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b0;
        #2;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rstmid_req: got %b want 0", mem_req_o); end
        checks++; if (sp_o !== 16'hFFFE) begin errors++; $display("FAIL rstmid_sp: got %h want fffe", sp_o); end
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", cmd_ready_o); end
        @(negedge clk_i);
        rst_ni    = 1'b1;
        manualAck = 1'b1;
        sawResp   = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (resp_valid_o !== 1'b0 || mem_req_o !== 1'b0) sawResp++;
        end
        checks++; if (sawResp !== 0) begin errors++; $display("FAIL rstmid_stray_ack: got %0d bad cycles want 0", sawResp); end
        checks++; if (sp_o !== 16'hFFFE) begin errors++; $display("FAIL rstmid_sp_after: got %h want fffe", sp_o); end
        manualAck = 1'b0;
        autoMem   = 1'b1;
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_push();
        test_pop();
        test_pop_wait();
        test_adjust();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
